keypad_entry_ctrl: RTL
======================

# keypad_entry_ctrl

Sequencer that sits directly behind the 4x4 hex keypad scanner and turns its per-key code pulses into multi-digit entries. Accumulates digit keys into a nibble shift buffer and handles the CLEAR, BACKSPACE and ENTER keys. Enforces an inactivity timeout and presents the completed value to downstream logic (display/PIN compare) over a valid/ready handshake.

## Interface
- DIGITS, 4: max digits held; o_Value width = 4*DIGITS.
- ENTER_CODE, 4'hF: scanner code committing the entry.
- CLEAR_CODE, 4'hE: scanner code clearing the buffer.
- BKSP_CODE, 4'hD: scanner code deleting the newest digit.
- TIMEOUT_CNT, 32'd499_999_999: idle cycles before auto-clear (5 s at 100 MHz); 0 disables the timeout.
- REPEAT_CNT, 32'd49_999_999: same-key lockout window in cycles (only with KEYPAD_REPEAT_FILTER_EN).

Ports:
- i_Clk  in  1  system clock, all logic on posedge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Num  in  4  key code from scanner.
- i_fDone  in  1  scanner code-complete strobe.
- i_Ready  in  1  downstream accepts o_Value.
- o_Value  out  4*DIGITS  entry buffer; newest digit in [3:0].
- o_Count  out  $clog2(DIGITS+1)  digits held.
- o_Valid  out  1  entry committed, awaiting i_Ready.
- o_Overflow  out  1  one-cycle pulse: digit dropped, buffer full.
- o_Timeout  out  1  one-cycle pulse: buffer auto-cleared.
- debug_State  out  2  current FSM state.

## Operation
- The scanner commits i_Num on the edge that ends i_fDone, so the block registers a pending flag on i_fDone and samples i_Num in the following cycle. Every key action uses that sampled code.
- States: IDLE=2'b00 (count 0), ENTRY=2'b01 (count 1..DIGITS), PRESENT=2'b10 (o_Valid high). 2'b11 is unused and recovers to IDLE.
- Digit key (any code other than ENTER/CLEAR/BKSP), IDLE/ENTRY:
  - count<DIGITS: o_Value <= {o_Value[4*DIGITS-5:0], code}, count+1, go to ENTRY.
  - count==DIGITS: buffer unchanged, o_Overflow pulses.
- BKSP: if count>0, o_Value <= {4'h0, o_Value[4*DIGITS-1:4]} and count-1; count reaching 0 goes to IDLE. If count==0, ignored.
- CLEAR: o_Value<=0, count<=0, go to IDLE.
- ENTER: if count>0, go to PRESENT; if count==0, ignored.
- PRESENT: all keys are dropped and never queued. o_Value/o_Count are held stable while o_Valid=1. On o_Valid&i_Ready, the next state is IDLE with buffer and count zeroed.
- Timeout: a 32-bit idle counter runs only in ENTRY and is zeroed by every accepted key and on leaving ENTRY. On reaching TIMEOUT_CNT, the buffer clears, the FSM goes to IDLE and o_Timeout pulses.
- Key sample and timeout in the same cycle: the key wins and the counter zeroes.
- Reset (any time, including mid-entry or in PRESENT): state IDLE, o_Value=0, o_Count=0, o_Valid=0, o_Overflow=0, o_Timeout=0, pending flag, idle counter and repeat tracker cleared. debug_State=2'b00.

## Timing
- i_fDone high in cycle n → i_Num sampled in cycle n+1 → o_Value/o_Count/state updated at the n+2 edge.
- ENTER strobe in cycle n → o_Valid high from the n+2 edge.
- Handshake completes in a cycle where o_Valid&i_Ready. o_Valid is low the next cycle. Zero-cycle combinational paths from i_Ready to outputs are forbidden.
- All outputs are registered. Each pulse output is exactly 1 cycle.
- Back-to-back i_fDone strobes (minimum spacing 2 cycles) must each be processed.

## Configuration
- KEYPAD_REPEAT_FILTER_EN defined:
  - Track the last accepted code and a cycle counter since it was accepted.
  - A sampled code equal to the last code while the counter < REPEAT_CNT is dropped with no side effects and does not reset the idle counter.
  - A different code is accepted immediately and restarts the window.
  - CLEAR, BKSP and ENTER are filtered too.
- Undefined: every strobe is processed. REPEAT_CNT is unused and no tracker logic is synthesised.

## Test plan
- Reset, then strobes 1,2,3,ENTER; ready held low 10 cycles, then high → o_Value=16'h0123 and o_Count=3 stable, o_Valid high 10 cycles, then IDLE with value 0.
- 5 digit strobes 1..5 with DIGITS=4 → o_Value=16'h1234, count 4, o_Overflow one pulse on the 5th; then BKSP → 16'h0123, count 3.
- 2 digits, then no keys with TIMEOUT_CNT=20 → o_Timeout pulse 21 cycles after the last key update, value 0, IDLE. Repeat with a key strobe landing on the timeout cycle → key accepted, no pulse.
- ENTER with count 0, and BKSP with count 0 → no state change, o_Valid stays 0. Keys during PRESENT → value unchanged.
- Assert i_Rst mid-entry (count 2) and again in PRESENT → all outputs 0 asynchronously, IDLE.
- With KEYPAD_REPEAT_FILTER_EN and REPEAT_CNT=30: strobes 7 at t=0, 7 at t=10, 8 at t=12, 8 at t=50 → o_Value=16'h0788, count 3. Without the macro → 16'h7788.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: turns keypad scanner code strobes into a multi-digit entry with valid/ready hand-off
// Optional same-key repeat filter enabled by defining KEYPAD_REPEAT_FILTER_EN.
module keypad_entry_ctrl #(
    parameter int          DIGITS      = 4,
    parameter logic [3:0]  ENTER_CODE  = 4'hF,
    parameter logic [3:0]  CLEAR_CODE  = 4'hE,
    parameter logic [3:0]  BKSP_CODE   = 4'hD,
    parameter logic [31:0] TIMEOUT_CNT = 32'd499_999_999,
    parameter logic [31:0] REPEAT_CNT  = 32'd49_999_999
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic [3:0]                    i_Num,
    input  logic                          i_fDone,
    input  logic                          i_Ready,
    output logic [4*DIGITS-1:0]           o_Value,
    output logic [$clog2(DIGITS+1)-1:0]   o_Count,
    output logic                          o_Valid,
    output logic                          o_Overflow,
    output logic                          o_Timeout,
    output logic [1:0]                    debug_State
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_ENTRY = 2'b01, S_PRESENT = 2'b10} state_t;

    state_t              state, state_n;
    logic [4*DIGITS-1:0] value_n;
    logic [CW-1:0]       count_n;
    logic [31:0]         idle, idle_n;
    logic                pend, key, ovf_n, tmo_n;

`ifdef KEYPAD_REPEAT_FILTER_EN
    logic [3:0]  last_code;
    logic        last_vld;
    logic [31:0] rep_cnt;

    assign key = pend && !(last_vld && i_Num == last_code && rep_cnt < REPEAT_CNT);

    // remember the last code that passed the filter and how long ago it did
    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) begin
            last_code <= 4'h0;
            last_vld  <= 1'b0;
            rep_cnt   <= 32'd0;
        end else if (key) begin
            last_code <= i_Num;
            last_vld  <= 1'b1;
            rep_cnt   <= 32'd0;
        end else if (rep_cnt < REPEAT_CNT) begin
            rep_cnt <= rep_cnt + 32'd1;
        end
`else
    assign key = pend;
`endif

    assign debug_State = state;

    // next-state and buffer update; the sampled code is i_Num in the cycle after i_fDone
    always_comb begin
        state_n = state;
        value_n = o_Value;
        count_n = o_Count;
        idle_n  = 32'd0;
        ovf_n   = 1'b0;
        tmo_n   = 1'b0;
        case (state)
            S_IDLE, S_ENTRY: begin
                if (key) begin
                    if (i_Num == CLEAR_CODE) begin
                        value_n = '0;
                        count_n = '0;
                        state_n = S_IDLE;
                    end else if (i_Num == BKSP_CODE) begin
                        if (o_Count != '0) begin
                            value_n = {4'h0, o_Value[4*DIGITS-1:4]};
                            count_n = o_Count - 1'b1;
                            state_n = (o_Count == CW'(1)) ? S_IDLE : S_ENTRY;
                        end
                    end else if (i_Num == ENTER_CODE) begin
                        state_n = (o_Count != '0) ? S_PRESENT : state;
                    end else if (o_Count == FULL) begin
                        ovf_n = 1'b1;
                    end else begin
                        value_n = {o_Value[4*DIGITS-5:0], i_Num};
                        count_n = o_Count + 1'b1;
                        state_n = S_ENTRY;
                    end
                end else if (state == S_ENTRY) begin
                    if (TIMEOUT_CNT != 32'd0 && idle == TIMEOUT_CNT) begin
                        value_n = '0;
                        count_n = '0;
                        state_n = S_IDLE;
                        tmo_n   = 1'b1;
                    end else begin
                        idle_n = idle + 32'd1;
                    end
                end
            end
            S_PRESENT: begin
                if (i_Ready) begin
                    value_n = '0;
                    count_n = '0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                value_n = '0;
                count_n = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // state, buffer and registered outputs
    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) begin
            state      <= S_IDLE;
            o_Value    <= '0;
            o_Count    <= '0;
            o_Valid    <= 1'b0;
            o_Overflow <= 1'b0;
            o_Timeout  <= 1'b0;
            pend       <= 1'b0;
            idle       <= 32'd0;
        end else begin
            state      <= state_n;
            o_Value    <= value_n;
            o_Count    <= count_n;
            o_Valid    <= (state_n == S_PRESENT);
            o_Overflow <= ovf_n;
            o_Timeout  <= tmo_n;
            pend       <= i_fDone;
            idle       <= idle_n;
        end
endmodule
